// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// registered match pulse and a saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0010_1111,
    parameter int                 RST_LEN     = 6,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   busy_len
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   cfg_len_sat;
    logic               ovl;
    logic               match;
    logic               hit;
    logic               unused_hist_msb;

    // The oldest history bit only ever shifts out; it never takes part in a compare.
    assign unused_hist_msb = hist[MAX_LEN-1];

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        hist_n      = {hist[MAX_LEN-2:0], x};
        fill_n      = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
        cfg_len_sat = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        match = (len != '0) && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
    end

    assign hit      = x_valid && !cfg_we && match;
    assign busy_len = len;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat         <= RST_PATTERN;
            len         <= RST_LEN_L;
            ovl         <= RST_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_we) begin
                pat  <= cfg_pattern;
                len  <= cfg_len_sat;
                ovl  <= cfg_overlap;
                hist <= '0;
                fill <= '0;
                z    <= 1'b0;
            end else if (x_valid) begin
                z <= match;
                // Non-overlapping mode restarts from an empty history after each hit.
                if (match && !ovl) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= hist_n;
                    fill <= fill_n;
                end
            end else begin
                z <= 1'b0;
            end

            if (cnt_clr) begin
                match_count <= '0;
            end else if (hit && match_count != CNT_MAX) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: table-driven vectors plus
// hand-written reset and counter-saturation sequences.
module tb_seq_detector_prog;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       x;
    logic       x_valid;
    logic       cnt_clr;
    logic       z;
    logic [7:0] match_count;
    logic [3:0] busy_len;
    logic       sat_z;
    logic [1:0] sat_count;
    logic [3:0] sat_busy;

    int checks = 0;
    int errors = 0;

    seq_detector_prog u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .x           (x),
        .x_valid     (x_valid),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .match_count (match_count),
        .busy_len    (busy_len)
    );

    seq_detector_prog #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .x           (x),
        .x_valid     (x_valid),
        .cnt_clr     (cnt_clr),
        .z           (sat_z),
        .match_count (sat_count),
        .busy_len    (sat_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       xb;
        logic       xv;
        logic       clr;
        logic       ez;
        logic [7:0] ecnt;
        logic [3:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [7:0] pat, logic [3:0] len, logic ovl,
                                logic xb, logic xv, logic clr,
                                logic ez, logic [7:0] ecnt, logic [3:0] ebusy);
        vec_t v;
        v.we = we; v.pat = pat; v.len = len; v.ovl = ovl;
        v.xb = xb; v.xv = xv; v.clr = clr;
        v.ez = ez; v.ecnt = ecnt; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic xb, input logic xv, input logic clr);
        cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        x = xb; x_valid = xv; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic xb);
        apply(1'b0, 8'h00, 4'd0, 1'b0, xb, 1'b1, 1'b0);
    endtask

    initial begin
        logic [8:0] rs_bits;
        logic [8:0] rs_z;
        logic [1:0] sat_exp[5];

        // Default pattern 101111, overlap: matches after bit 6 and bit 11.
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 2, 6));
        // Same pattern, non-overlap; same-cycle bit discarded, counter cleared.
        vecs.push_back(mk(1, 8'h2F, 6, 0, 1, 1, 1, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 6));
        // Pattern 11, overlap: back-to-back pulses, then gapped x_valid.
        vecs.push_back(mk(1, 8'h03, 2, 1, 0, 0, 1, 0, 0, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 2, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 3, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 4, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 5, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 5, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 6, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 6, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 6, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 6, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 7, 2));
        // len 0 disables detection and freezes the counter.
        vecs.push_back(mk(1, 8'h03, 0, 1, 0, 0, 0, 0, 7, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 0));
        // len 15 clamps to 8; full-width pattern 10100101.
        vecs.push_back(mk(1, 8'hA5, 15, 1, 0, 0, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 7, 8));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 8, 8));

        cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        x = 0; x_valid = 0; cnt_clr = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", 32'(z), 0);
        check("reset_count", 32'(match_count), 0);
        check("reset_busy_len", 32'(busy_len), 6);
        check("reset_sat_count", 32'(sat_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].we, vecs[i].pat, vecs[i].len, vecs[i].ovl,
                  vecs[i].xb, vecs[i].xv, vecs[i].clr);
            check($sformatf("vec%0d_z", i), 32'(z), 32'(vecs[i].ez));
            check($sformatf("vec%0d_count", i), 32'(match_count), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_busy_len", i), 32'(busy_len), 32'(vecs[i].ebusy));
        end

        // Asynchronous reset while z is high clears outputs without a clock edge.
        x_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_z", 32'(z), 0);
        check("async_rst_count", 32'(match_count), 0);
        check("async_rst_busy_len", 32'(busy_len), 6);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial 101 lost by a mid-pattern reset; 1111 must not complete it.
        send(1'b1);
        send(1'b0);
        send(1'b1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rs_bits = 9'b1_1110_1111;
        rs_z    = 9'b1_0000_0000;
        for (int i = 0; i < 9; i++) begin
            send(rs_bits[i]);
            check($sformatf("restart_bit%0d_z", i), 32'(z), 32'(rs_z[i]));
        end
        check("restart_count", 32'(match_count), 1);

        // 2-bit counter saturates at 3; clear beats a same-cycle increment.
        apply(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("sat_cfg_count", 32'(sat_count), 0);
        check("sat_cfg_busy_len", 32'(sat_busy), 1);
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            check($sformatf("sat_match%0d_z", i), 32'(sat_z), 1);
            check($sformatf("sat_match%0d_count", i), 32'(sat_count), 32'(sat_exp[i]));
        end
        apply(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("sat_clr_z", 32'(sat_z), 1);
        check("sat_clr_count", 32'(sat_count), 0);
        send(1'b1);
        check("sat_after_clr_count", 32'(sat_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
